// File: rtl/idexe_pipe_reg_pkg.sv
// Shared CPU definitions: datapath defaults, ALU encodings and
// the ID/EX control bundle used by the pipeline register.
package idexe_pipe_reg_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int RN_W_DEF   = 5;
   localparam int ALUC_W_DEF = 4;
   localparam int CNT_W_DEF  = 16;
   localparam int CTL_W      = 6;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_LUI  = 4'h5,
      ALU_SLL  = 4'h6,
      ALU_SRL  = 4'h7,
      ALU_SRA  = 4'h8,
      ALU_SLT  = 4'h9,
      ALU_SLTU = 4'ha
   } aluc_e;

   typedef enum logic [1:0] {
      SEL_HOLD  = 2'd0,
      SEL_FLUSH = 2'd1,
      SEL_LU    = 2'd2,
      SEL_LOAD  = 2'd3
   } sel_e;

   typedef struct packed {
      logic wreg;
      logic m2reg;
      logic wmem;
      logic jal;
      logic aluimm;
      logic shift;
   } ctl_t;

   function automatic ctl_t ctl_gate(input ctl_t c, input logic v);
      return v ? c : '0;
   endfunction

endpackage

// File: rtl/idexe_pipe_reg_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read
// by the valid instruction in ID. Register 0 is never a hazard.
module load_use_detect #(
   parameter int RN_W = 5
) (
   input  logic            ev_i,
   input  logic            em2reg_i,
   input  logic            ewreg_i,
   input  logic [RN_W-1:0] ern_i,
   input  logic            dvalid_i,
   input  logic [RN_W-1:0] drs_i,
   input  logic [RN_W-1:0] drt_i,
   input  logic            drs_used_i,
   input  logic            drt_used_i,
   output logic            lu_o
);

   logic e_load;
   logic rs_hit;
   logic rt_hit;

   assign e_load = ev_i & em2reg_i & ewreg_i & (|ern_i);
   assign rs_hit = drs_used_i & (drs_i == ern_i);
   assign rt_hit = drt_used_i & (drt_i == ern_i);
   assign lu_o   = e_load & dvalid_i & (rs_hit | rt_hit);

endmodule

// File: rtl/idexe_pipe_reg.sv
// ID/EX pipeline register with valid bit, hold, flush, automatic
// load-use bubble insertion and saturating bubble counters.
module idexe_pipe_reg
   import idexe_pipe_reg_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int RN_W   = RN_W_DEF,
   parameter int ALUC_W = ALUC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_ext,
   input  logic              flush,
   input  logic              dvalid,
   input  logic              dwreg,
   input  logic              dm2reg,
   input  logic              dwmem,
   input  logic              djal,
   input  logic              daluimm,
   input  logic              dshift,
   input  logic [ALUC_W-1:0] daluc,
   input  logic [XLEN-1:0]   dpc4,
   input  logic [XLEN-1:0]   dimm,
   input  logic [XLEN-1:0]   da,
   input  logic [XLEN-1:0]   db,
   input  logic [RN_W-1:0]   drn,
   input  logic [RN_W-1:0]   drs,
   input  logic [RN_W-1:0]   drt,
   input  logic              drs_used,
   input  logic              drt_used,
   output logic              ev,
   output logic              ewreg,
   output logic              em2reg,
   output logic              ewmem,
   output logic              ejal,
   output logic              ealuimm,
   output logic              eshift,
   output logic [ALUC_W-1:0] ealuc,
   output logic [XLEN-1:0]   epc4,
   output logic [XLEN-1:0]   eimm,
   output logic [XLEN-1:0]   ea,
   output logic [XLEN-1:0]   eb,
   output logic [RN_W-1:0]   ern,
   output logic              load_use_stall,
   output logic [CNT_W-1:0]  lu_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic              ev_q,        ev_d;
   ctl_t              ctl_q,       ctl_d;
   logic [ALUC_W-1:0] aluc_q,      aluc_d;
   logic [XLEN-1:0]   pc4_q,       pc4_d;
   logic [XLEN-1:0]   imm_q,       imm_d;
   logic [XLEN-1:0]   a_q,         a_d;
   logic [XLEN-1:0]   b_q,         b_d;
   logic [RN_W-1:0]   rn_q,        rn_d;
   logic [CNT_W-1:0]  lu_cnt_q,    lu_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic lu;
   sel_e sel;
   ctl_t d_ctl;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] c
   );
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   load_use_detect #(
      .RN_W (RN_W)
   ) u_lud (
      .ev_i       (ev_q),
      .em2reg_i   (ctl_q.m2reg),
      .ewreg_i    (ctl_q.wreg),
      .ern_i      (rn_q),
      .dvalid_i   (dvalid),
      .drs_i      (drs),
      .drt_i      (drt),
      .drs_used_i (drs_used),
      .drt_used_i (drt_used),
      .lu_o       (lu)
   );

   assign d_ctl = '{
      wreg:   dwreg,
      m2reg:  dm2reg,
      wmem:   dwmem,
      jal:    djal,
      aluimm: daluimm,
      shift:  dshift
   };

   // Overlapping requests are legal here, hence priority not unique.
   always_comb begin
      sel = SEL_LOAD;
      priority case (1'b1)
         stall_ext: sel = SEL_HOLD;
         flush:     sel = SEL_FLUSH;
         lu:        sel = SEL_LU;
         default:   sel = SEL_LOAD;
      endcase
   end

   assign load_use_stall = lu & ~flush & ~stall_ext;

   always_comb begin
      ev_d        = ev_q;
      ctl_d       = ctl_q;
      aluc_d      = aluc_q;
      pc4_d       = pc4_q;
      imm_d       = imm_q;
      a_d         = a_q;
      b_d         = b_q;
      rn_d        = rn_q;
      lu_cnt_d    = lu_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (sel)
         SEL_HOLD: ;
         SEL_FLUSH, SEL_LU: begin
            ev_d   = 1'b0;
            ctl_d  = '0;
            aluc_d = '0;
            pc4_d  = '0;
            imm_d  = '0;
            a_d    = '0;
            b_d    = '0;
            rn_d   = '0;
            if (sel == SEL_FLUSH) flush_cnt_d = sat_inc(flush_cnt_q);
            else                  lu_cnt_d    = sat_inc(lu_cnt_q);
         end
         SEL_LOAD: begin
            ev_d   = dvalid;
            ctl_d  = ctl_gate(d_ctl, dvalid);
            aluc_d = daluc;
            pc4_d  = dpc4;
            imm_d  = dimm;
            a_d    = da;
            b_d    = db;
            rn_d   = drn;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ev_q        <= 1'b0;
         ctl_q       <= '0;
         aluc_q      <= '0;
         pc4_q       <= '0;
         imm_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rn_q        <= '0;
         lu_cnt_q    <= '0;
         flush_cnt_q <= '0;
      end else begin
         ev_q        <= ev_d;
         ctl_q       <= ctl_d;
         aluc_q      <= aluc_d;
         pc4_q       <= pc4_d;
         imm_q       <= imm_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rn_q        <= rn_d;
         lu_cnt_q    <= lu_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ev        = ev_q;
   assign ewreg     = ctl_q.wreg;
   assign em2reg    = ctl_q.m2reg;
   assign ewmem     = ctl_q.wmem;
   assign ejal      = ctl_q.jal;
   assign ealuimm   = ctl_q.aluimm;
   assign eshift    = ctl_q.shift;
   assign ealuc     = aluc_q;
   assign epc4      = pc4_q;
   assign eimm      = imm_q;
   assign ea        = a_q;
   assign eb        = b_q;
   assign ern       = rn_q;
   assign lu_cnt    = lu_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_idexe_pipe_reg.sv
// Directed vector bench for idexe_pipe_reg, plus a CNT_W=2 instance
// sharing the same inputs for counter saturation.
module tb_idexe_pipe_reg;

   logic        clk = 1'b0;
   logic        rst, stall_ext, flush, dvalid;
   logic        dwreg, dm2reg, dwmem, djal, daluimm, dshift;
   logic [3:0]  daluc;
   logic [31:0] dpc4, dimm, da, db;
   logic [4:0]  drn, drs, drt;
   logic        drs_used, drt_used;

   logic        ev, ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
   logic [3:0]  ealuc;
   logic [31:0] epc4, eimm, ea, eb;
   logic [4:0]  ern;
   logic        load_use_stall;
   logic [15:0] lu_cnt, flush_cnt;

   logic        x_ev, x_ewreg, x_em2reg, x_ewmem, x_ejal, x_ealuimm;
   logic        x_eshift;
   logic [3:0]  x_ealuc;
   logic [31:0] x_epc4, x_eimm, x_ea, x_eb;
   logic [4:0]  x_ern;
   logic        x_lus;
   logic [1:0]  x_lu_cnt, x_flush_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   idexe_pipe_reg dut (
      .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush(flush),
      .dvalid(dvalid), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
      .djal(djal), .daluimm(daluimm), .dshift(dshift), .daluc(daluc),
      .dpc4(dpc4), .dimm(dimm), .da(da), .db(db), .drn(drn),
      .drs(drs), .drt(drt), .drs_used(drs_used), .drt_used(drt_used),
      .ev(ev), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
      .ejal(ejal), .ealuimm(ealuimm), .eshift(eshift), .ealuc(ealuc),
      .epc4(epc4), .eimm(eimm), .ea(ea), .eb(eb), .ern(ern),
      .load_use_stall(load_use_stall), .lu_cnt(lu_cnt),
      .flush_cnt(flush_cnt)
   );

   idexe_pipe_reg #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush(flush),
      .dvalid(dvalid), .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem),
      .djal(djal), .daluimm(daluimm), .dshift(dshift), .daluc(daluc),
      .dpc4(dpc4), .dimm(dimm), .da(da), .db(db), .drn(drn),
      .drs(drs), .drt(drt), .drs_used(drs_used), .drt_used(drt_used),
      .ev(x_ev), .ewreg(x_ewreg), .em2reg(x_em2reg), .ewmem(x_ewmem),
      .ejal(x_ejal), .ealuimm(x_ealuimm), .eshift(x_eshift),
      .ealuc(x_ealuc), .epc4(x_epc4), .eimm(x_eimm), .ea(x_ea),
      .eb(x_eb), .ern(x_ern), .load_use_stall(x_lus),
      .lu_cnt(x_lu_cnt), .flush_cnt(x_flush_cnt)
   );

   typedef struct {
      logic        fl, st, dv;
      logic [5:0]  ctl;
      logic [3:0]  aluc;
      logic [31:0] pc4, imm, a, b;
      logic [4:0]  rn, rs, rt;
      logic        rsu, rtu;
   } din_t;

   typedef struct {
      logic        lus, ev;
      logic [5:0]  ctl;
      logic [3:0]  aluc;
      logic [31:0] pc4, imm, a, b;
      logic [4:0]  rn;
      logic [15:0] luc, flc;
   } exp_t;

   localparam int NV = 19;
   din_t vd[NV];
   exp_t ve[NV];

   function automatic din_t fD(
      input logic fl, st, dv, input logic [5:0] ctl,
      input logic [3:0] aluc, input logic [31:0] pc4, imm, a, b,
      input logic [4:0] rn, rs, rt, input logic rsu, rtu);
      din_t r;
      r.fl = fl; r.st = st; r.dv = dv; r.ctl = ctl; r.aluc = aluc;
      r.pc4 = pc4; r.imm = imm; r.a = a; r.b = b;
      r.rn = rn; r.rs = rs; r.rt = rt; r.rsu = rsu; r.rtu = rtu;
      return r;
   endfunction

   function automatic exp_t fE(
      input logic lus, ev, input logic [5:0] ctl,
      input logic [3:0] aluc, input logic [31:0] pc4, imm, a, b,
      input logic [4:0] rn, input logic [15:0] luc, flc);
      exp_t r;
      r.lus = lus; r.ev = ev; r.ctl = ctl; r.aluc = aluc;
      r.pc4 = pc4; r.imm = imm; r.a = a; r.b = b; r.rn = rn;
      r.luc = luc; r.flc = flc;
      return r;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s [%0d] got %h expected %h", nm, idx, got, exp);
      end
   endtask

   task automatic drive(input din_t d);
      flush    = d.fl;
      stall_ext = d.st;
      dvalid   = d.dv;
      {dwreg, dm2reg, dwmem, djal, daluimm, dshift} = d.ctl;
      daluc    = d.aluc;
      dpc4     = d.pc4;
      dimm     = d.imm;
      da       = d.a;
      db       = d.b;
      drn      = d.rn;
      drs      = d.rs;
      drt      = d.rt;
      drs_used = d.rsu;
      drt_used = d.rtu;
   endtask

   task automatic chk_e(input int i, input exp_t e);
      chk("ev", i, 32'(ev), 32'(e.ev));
      chk("ctl", i,
          32'({ewreg, em2reg, ewmem, ejal, ealuimm, eshift}),
          32'(e.ctl));
      chk("ealuc", i, 32'(ealuc), 32'(e.aluc));
      chk("epc4", i, epc4, e.pc4);
      chk("eimm", i, eimm, e.imm);
      chk("ea", i, ea, e.a);
      chk("eb", i, eb, e.b);
      chk("ern", i, 32'(ern), 32'(e.rn));
      chk("lu_cnt", i, 32'(lu_cnt), 32'(e.luc));
      chk("flush_cnt", i, 32'(flush_cnt), 32'(e.flc));
   endtask

   initial begin
      exp_t z;
      vd[0]  = fD(0,0,1,6'b100000,2,'h104,'h10,'hDEADBEEF,'h55,7,1,2,1,1);
      ve[0]  = fE(0,1,6'b100000,2,'h104,'h10,'hDEADBEEF,'h55,7,0,0);
      vd[1]  = fD(0,0,1,6'b110000,0,'h108,4,'h1000,0,5,7,0,1,0);
      ve[1]  = fE(0,1,6'b110000,0,'h108,4,'h1000,0,5,0,0);
      vd[2]  = fD(0,0,1,6'b100000,3,'h10C,0,'h11,'h22,6,5,3,1,1);
      ve[2]  = fE(1,0,0,0,0,0,0,0,0,1,0);
      vd[3]  = vd[2];
      ve[3]  = fE(0,1,6'b100000,3,'h10C,0,'h11,'h22,6,1,0);
      vd[4]  = fD(0,0,1,6'b110000,0,'h110,8,'h2000,0,0,6,6,0,0);
      ve[4]  = fE(0,1,6'b110000,0,'h110,8,'h2000,0,0,1,0);
      vd[5]  = fD(0,0,1,6'b000010,1,'h114,1,3,4,9,0,0,1,1);
      ve[5]  = fE(0,1,6'b000010,1,'h114,1,3,4,9,1,0);
      vd[6]  = fD(0,0,1,6'b110000,0,'h118,0,4,0,12,9,0,1,0);
      ve[6]  = fE(0,1,6'b110000,0,'h118,0,4,0,12,1,0);
      vd[7]  = fD(0,0,1,6'b001001,5,'h11C,2,5,6,0,12,12,0,1);
      ve[7]  = fE(1,0,0,0,0,0,0,0,0,2,0);
      vd[8]  = vd[7];
      ve[8]  = fE(0,1,6'b001001,5,'h11C,2,5,6,0,2,0);
      vd[9]  = fD(0,0,1,6'b110000,0,'h120,0,8,0,3,0,0,0,0);
      ve[9]  = fE(0,1,6'b110000,0,'h120,0,8,0,3,2,0);
      vd[10] = fD(1,0,1,6'b100000,0,'h124,0,0,0,1,3,0,1,0);
      ve[10] = fE(0,0,0,0,0,0,0,0,0,2,1);
      vd[11] = fD(0,0,0,6'b111111,0,'h128,9,'hAAAA,'hBBBB,0,0,0,0,0);
      ve[11] = fE(0,0,0,0,'h128,9,'hAAAA,'hBBBB,0,2,1);
      vd[12] = fD(0,0,1,6'b110000,0,'h12C,0,'h77,0,8,0,0,0,0);
      ve[12] = fE(0,1,6'b110000,0,'h12C,0,'h77,0,8,2,1);
      vd[13] = fD(0,1,1,6'b100000,1,'h130,1,1,1,2,8,8,1,1);
      ve[13] = ve[12];
      vd[14] = fD(0,1,1,6'b000001,2,'h134,2,2,2,3,8,0,1,0);
      ve[14] = ve[12];
      vd[15] = fD(0,1,0,6'b111111,3,'h138,3,3,3,4,0,8,0,1);
      ve[15] = ve[12];
      vd[16] = fD(1,1,1,6'b100000,4,'h13C,4,4,4,5,8,0,1,0);
      ve[16] = ve[12];
      vd[17] = fD(1,0,1,6'b100000,4,'h13C,4,4,4,5,8,0,1,0);
      ve[17] = fE(0,0,0,0,0,0,0,0,0,2,2);
      vd[18] = fD(0,0,1,6'b000100,9,'h140,0,0,0,31,8,8,1,1);
      ve[18] = fE(0,1,6'b000100,9,'h140,0,0,0,31,2,2);

      // reset with random D-side inputs
      rst = 1'b1;
      drive(fD($urandom, $urandom, $urandom, 6'($urandom), 4'($urandom),
               $urandom, $urandom, $urandom, $urandom, 5'($urandom),
               5'($urandom), 5'($urandom), $urandom, $urandom));
      repeat (2) @(posedge clk);
      #1;
      z = fE(0,0,0,0,0,0,0,0,0,0,0);
      chk_e(-1, z);
      chk("rst_lus", -1, 32'(load_use_stall), 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vd[i]);
         #1;
         chk("load_use_stall", i, 32'(load_use_stall), 32'(ve[i].lus));
         @(posedge clk);
         #1;
         chk_e(i, ve[i]);
         chk("x_lu_cnt", i, 32'(x_lu_cnt), 32'(ve[i].luc));
         chk("x_flush_cnt", i, 32'(x_flush_cnt), 32'(ve[i].flc));
      end

      // five back-to-back flushes: narrow counter pins at 3
      drive(fD(1,0,1,6'b100000,1,'h200,0,1,1,1,0,0,0,0));
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         chk("sat_ev", k, 32'(ev), 0);
         chk("sat_flush_cnt", k, 32'(flush_cnt), 32'(2 + k));
         chk("sat_x_flush_cnt", k, 32'(x_flush_cnt),
             (2 + k > 3) ? 32'd3 : 32'(2 + k));
      end

      // reset arriving during an external stall clears everything
      drive(fD(0,0,1,6'b110000,0,'h300,5,6,7,4,0,0,0,0));
      @(posedge clk);
      #1;
      chk("pre_rst_ev", 0, 32'(ev), 1);
      stall_ext = 1'b1;
      flush     = 1'b1;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      chk_e(100, z);
      chk("rst_x_flush_cnt", 100, 32'(x_flush_cnt), 0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule

// File: doc/idexe_pipe_reg.md
# idexe_pipe_reg

Parametrised ID/EX pipeline register for the five-stage CPU, the successor to the fixed-width, free-running ID/EX latch. It adds a valid bit, synchronous reset, external stall (hold), branch flush (bubble), built-in load-use hazard detection with automatic bubble insertion, and saturating hazard counters. It sits between the decode stage and the ALU/EX stage; its `load_use_stall` output gates the PC and IF/ID registers.

## Interface
Parameters:
- `XLEN`, 32, datapath width of `pc4`/`imm`/`a`/`b`
- `RN_W`, 5, register-number width
- `ALUC_W`, 4, ALU control width
- `CNT_W`, 16, hazard counter width

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall_ext`  in  1  downstream stall; hold all state
- `flush`  in  1  kill the instruction in ID; sampled only when `stall_ext`=0
- `dvalid`  in  1  ID holds a real instruction
- `dwreg`, `dm2reg`, `dwmem`, `djal`, `daluimm`, `dshift`  in  1 each  decoded controls
- `daluc`  in  ALUC_W  ALU operation
- `dpc4`, `dimm`, `da`, `db`  in  XLEN each  decoded data
- `drn`  in  RN_W  destination register
- `drs`, `drt`  in  RN_W each  source register numbers
- `drs_used`, `drt_used`  in  1 each  instruction reads rs / rt
- `ev`  out  1  EX-stage valid
- `ewreg`, `em2reg`, `ewmem`, `ejal`, `ealuimm`, `eshift`  out  1 each  registered controls
- `ealuc`  out  ALUC_W
- `epc4`, `eimm`, `ea`, `eb`  out  XLEN each
- `ern`  out  RN_W
- `load_use_stall`  out  1  combinational; freeze PC and IF/ID
- `lu_cnt`, `flush_cnt`  out  CNT_W each  saturating bubble counters

## Operation
- Hazard: `lu` = `ev` & `em2reg` & `ewreg` & (`ern`≠0) & `dvalid` & ((`drs_used` & `drs`==`ern`) | (`drt_used` & `drt`==`ern`)).
- `load_use_stall` = `lu` & ~`flush` & ~`stall_ext`.
- Next-state priority per edge:
  - `rst`: every output register to 0, counters to 0.
  - else `stall_ext`: hold all registers and counters.
  - else `flush`: load bubble; `flush_cnt`+1 saturating.
  - else `lu`: load bubble; `lu_cnt`+1 saturating.
  - else: load all D-side fields; `ev` ← `dvalid`.
- Bubble: `ev`, all control outputs, `ealuc`, data fields and `ern` all forced to 0.
- Loading with `dvalid`=0: controls forced to 0 (write-enables never asserted on an invalid slot); data fields are loaded unchanged.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- Register 0 never raises a hazard.

## Timing
- Latency: D inputs appear on E outputs one cycle after the accepting edge.
- Load-use inserts exactly one bubble. Next cycle `ev`=0 so `lu`=0, and the held ID instruction advances.
- `load_use_stall` is combinational from E registers and D inputs, with no registered delay.
- `stall_ext` and `flush` asserted together: hold wins. The flush source keeps `flush` asserted until `stall_ext` deasserts.
- `flush` and hazard together: flush wins; `load_use_stall`=0; only `flush_cnt` increments.
- `rst` mid-stall or mid-bubble: cleared on that edge. `rst` overrides all other inputs.

## Structure
- The shared CPU package holds ALU control encodings (`ALUC_W`-wide), `XLEN` and `RN_W` defaults.
- One sub-module, `load_use_detect`, is combinational and computes `lu` from E-side and D-side fields. It is reused by the future MEM-stage forwarding unit.
- `idexe_pipe_reg` contains the register bank, priority mux and counters.

## Test plan
- Reset: drive `rst`=1 with random inputs for 2 cycles -> all outputs 0, `lu_cnt`=`flush_cnt`=0.
- Pass-through: `dvalid`=1, `dpc4`=0x00000104, `da`=0xDEADBEEF, `drn`=7, `dwreg`=1 -> next cycle `ev`=1, `epc4`=0x104, `ea`=0xDEADBEEF, `ern`=7, `ewreg`=1.
- Load-use: E holds load (`em2reg`=`ewreg`=1, `ern`=5), D has `drs`=5 with `drs_used`=1 -> `load_use_stall`=1 that cycle; next cycle `ev`=0, `lu_cnt`=1; following cycle the D instruction is loaded. The same case with `ern`=0 -> no stall.
- Stall hold: load a value, assert `stall_ext` for 3 cycles while changing D inputs -> E outputs and counters unchanged; `load_use_stall`=0.
- Flush priority: `flush`=1 with a simultaneous load-use hazard -> bubble, `flush_cnt`+1, `lu_cnt` unchanged. `flush` together with `stall_ext` -> hold.
- Saturation: `CNT_W`=2, 5 consecutive flushes -> `flush_cnt` stays at 3.
